pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 64: width of one datapath word.
REQ-002 Parameter NUM_DATA, default 5: number of datapath words carried (PC+4, DataA, DataB, Imm9, Imm12).
REQ-003 Parameter CTRL_W, default 11: width of packed control field (ALUOp 3, ALUSrc 2, Mem2Reg 2, MemWrite, MemRead, RegWrite, FlagWrite).
REQ-004 Parameter ADDR_W, default 5: destination register address width.
REQ-005 Parameter CNT_W, default 16: width of the stall and flush event counters.
REQ-006 Parameter STALL_LIMIT, default 8: consecutive-stall count that raises stall_long; legal range 1 to 2^CNT_W-1.
REQ-007 clk  in  1  single clock; all state updates on the rising edge.
REQ-008 reset  in  1  asynchronous, active-low reset (asserted at 0).
REQ-009 in_valid  in  1  upstream stage holds a real instruction.
REQ-010 stall  in  1  hold all stage contents this cycle.
REQ-011 flush  in  1  squash stage contents (insert bubble).
REQ-012 clr_cnt  in  1  synchronous clear of stall_cnt and flush_cnt.
REQ-013 in_data  in  NUM_DATA*DATA_W  concatenated datapath words, word 0 in LSBs.
REQ-014 in_ctrl  in  CTRL_W  packed control field.
REQ-015 in_addr  in  ADDR_W  destination register address.
REQ-016 out_valid, out_data, out_ctrl, out_addr  out  1 / NUM_DATA*DATA_W / CTRL_W / ADDR_W  registered stage contents.
REQ-017 stall_cnt, flush_cnt  out  CNT_W  saturating event counters.
REQ-018 stall_long  out  1  registered flag: current stall run has reached STALL_LIMIT.

Function
REQ-019 Latency SHALL be one clock: contents loaded at edge N appear on outputs after edge N.
REQ-020 Per-edge priority SHALL be flush > stall > load.
REQ-021 Flush: out_valid<=0, out_ctrl<=0; out_data and out_addr hold.
REQ-022 Stall (flush=0): all out_* hold unchanged.
REQ-023 Load (flush=0, stall=0): out_data<=in_data, out_addr<=in_addr, out_valid<=in_valid, out_ctrl<=in_valid ? in_ctrl : 0.
REQ-024 out_ctrl SHALL be all-zero whenever out_valid=0, so a bubble never writes registers, memory or flags.
REQ-025 stall_cnt SHALL increment on each edge with stall=1 and flush=0, saturating at 2^CNT_W-1.
REQ-026 flush_cnt SHALL increment on each edge with flush=1 and out_valid=1 (real instruction squashed), saturating at 2^CNT_W-1.
REQ-027 clr_cnt=1 SHALL zero both counters on that edge, overriding any same-edge increment.
REQ-028 Internal stall-run counter (CNT_W bits): increments on stall=1 and flush=0, saturates at STALL_LIMIT, clears to 0 on any edge with stall=0 or flush=1.
REQ-029 stall_long SHALL be 1 exactly while the stall-run counter equals STALL_LIMIT.
REQ-030 stall=1 and flush=1 together SHALL behave as flush only; run counter cleared, stall_cnt not incremented.

Reset
REQ-031 reset=0 SHALL immediately, without a clock, force out_valid, out_data, out_ctrl, out_addr, stall_cnt, flush_cnt, the run counter and stall_long to 0.
REQ-032 Reset asserted mid-stall SHALL discard the held instruction; the first edge after deassertion obeys REQ-020 normally.

Structure
REQ-033 Shared package pipe_pkg SHALL hold default DATA_W/CTRL_W/ADDR_W/CNT_W and localparams for control-field bit positions.
REQ-034 The saturating counter with synchronous clear SHALL be one sub-module, sat_counter (parameter W), instantiated for stall_cnt, flush_cnt and the run counter.

Verification
REQ-035 Load: in_valid=1, in_ctrl=11'h7FF, in_addr=5'd17, word0=64'h1000 -> after one edge out_valid=1, out_ctrl=11'h7FF, out_addr=17, word0=64'h1000.
REQ-036 Bubble: in_valid=0, in_ctrl=11'h7FF -> out_valid=0, out_ctrl=0.
REQ-037 Stall 3 cycles with changing inputs -> outputs unchanged, stall_cnt=3; flush on next edge with out_valid=1 -> out_valid=0, out_ctrl=0, flush_cnt=1.
REQ-038 STALL_LIMIT=4, stall held 6 cycles -> stall_long rises after 4th edge, stays 1; stall=0 for one edge -> stall_long=0.
REQ-039 CNT_W=3: 9 stall cycles -> stall_cnt=7; then clr_cnt=1 with stall=1 -> stall_cnt=0.
REQ-040 reset pulsed low between clock edges during a stall -> all outputs 0 before next edge; load after release behaves as REQ-035.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: default widths and
// the bit layout of the packed control field.
package pipe_pkg;

    localparam int DATA_W_DEF   = 64;
    localparam int NUM_DATA_DEF = 5;
    localparam int CTRL_W_DEF   = 11;
    localparam int ADDR_W_DEF   = 5;
    localparam int CNT_W_DEF    = 16;

    // Control-field bit positions (LSB of each sub-field) and sub-field widths.
    localparam int CTRL_FLAGWRITE   = 0;
    localparam int CTRL_REGWRITE    = 1;
    localparam int CTRL_MEMREAD     = 2;
    localparam int CTRL_MEMWRITE    = 3;
    localparam int CTRL_MEM2REG_LSB = 4;
    localparam int CTRL_MEM2REG_W   = 2;
    localparam int CTRL_ALUSRC_LSB  = 6;
    localparam int CTRL_ALUSRC_W    = 2;
    localparam int CTRL_ALUOP_LSB   = 8;
    localparam int CTRL_ALUOP_W     = 3;

    // Structured view of the default 11-bit control field, MSB first.
    typedef struct packed {
        logic [CTRL_ALUOP_W-1:0]   alu_op;
        logic [CTRL_ALUSRC_W-1:0]  alu_src;
        logic [CTRL_MEM2REG_W-1:0] mem2reg;
        logic                      mem_write;
        logic                      mem_read;
        logic                      reg_write;
        logic                      flag_write;
    } ctrl_t;

    // True when a control word would change architectural state.
    function automatic logic ctrl_has_write(input ctrl_t c);
        return c.mem_write | c.reg_write | c.flag_write;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that saturates at MAX, with a synchronous clear that takes
// priority over a same-edge increment.
module sat_counter #(
    parameter int           W   = 16,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count register: clear wins, otherwise step until MAX is reached.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != MAX)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// One pipeline stage register with flush/stall control, bubble-safe control
// field, saturating stall/flush event counters and a long-stall flag.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int NUM_DATA    = NUM_DATA_DEF,
    parameter int CTRL_W      = CTRL_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int STALL_LIMIT = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic                       stall,
    input  logic                       flush,
    input  logic                       clr_cnt,
    input  logic [NUM_DATA*DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0]          in_ctrl,
    input  logic [ADDR_W-1:0]          in_addr,
    output logic                       out_valid,
    output logic [NUM_DATA*DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0]          out_ctrl,
    output logic [ADDR_W-1:0]          out_addr,
    output logic [CNT_W-1:0]           stall_cnt,
    output logic [CNT_W-1:0]           flush_cnt,
    output logic                       stall_long
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STALL_LIMIT);

    // A stall only takes effect when no flush is present on the same edge.
    logic eff_stall;
    logic squash;
    logic [CNT_W-1:0] run_cnt;

    assign eff_stall = stall & ~flush;
    assign squash    = flush & out_valid;

    // Stage contents: flush bubbles, stall holds, otherwise load upstream.
    // NOTE: every flop here uses <= so all registers see pre-edge values;
    // a blocking = would let later statements observe this edge's update.
    // NOTE: the wide datapath registers are reset as well, because reset
    // must clear out_data/out_addr immediately, not just the valid bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ctrl  <= '0;
            out_addr  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_ctrl  <= '0;
        end else if (!stall) begin
            out_valid <= in_valid;
            out_data  <= in_data;
            out_ctrl  <= in_valid ? in_ctrl : '0;
            out_addr  <= in_addr;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clr_cnt),
        .inc   (eff_stall),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clr_cnt),
        .inc   (squash),
        .count (flush_cnt)
    );

    // Length of the current stall run; any non-stalling edge restarts it.
    sat_counter #(.W(CNT_W), .MAX(LIMIT)) u_run_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (~eff_stall),
        .inc   (eff_stall),
        .count (run_cnt)
    );

    // Flag tracks the run counter's next value, so it is high exactly while
    // the run counter sits at LIMIT (run_cnt never exceeds LIMIT).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_long <= 1'b0;
        end else begin
            stall_long <= eff_stall && (run_cnt >= LIMIT - CNT_W'(1));
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: two instances (default parameters, and a small
// CNT_W=3 / STALL_LIMIT=4 build) share stimulus and are compared against a
// behavioural model of the stage and its event counts.
module tb_pipe_stage_reg;

    localparam int DW = 64;
    localparam int ND = 5;
    localparam int BW = DW * ND;
    localparam int CW = 11;
    localparam int AW = 5;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          stall;
    logic          flush;
    logic          clr_cnt;
    logic [BW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic [AW-1:0] in_addr;

    logic          out_valid_a, out_valid_b;
    logic [BW-1:0] out_data_a, out_data_b;
    logic [CW-1:0] out_ctrl_a, out_ctrl_b;
    logic [AW-1:0] out_addr_a, out_addr_b;
    logic [15:0]   stall_cnt_a, flush_cnt_a;
    logic [2:0]    stall_cnt_b, flush_cnt_b;
    logic          stall_long_a, stall_long_b;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Model state: stage contents plus raw event tallies since last clear.
    logic          m_valid;
    logic [BW-1:0] m_data;
    logic [CW-1:0] m_ctrl;
    logic [AW-1:0] m_addr;
    int            m_stall_ev;
    int            m_flush_ev;
    int            m_run;

    pipe_stage_reg dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall),
        .flush(flush), .clr_cnt(clr_cnt), .in_data(in_data),
        .in_ctrl(in_ctrl), .in_addr(in_addr), .out_valid(out_valid_a),
        .out_data(out_data_a), .out_ctrl(out_ctrl_a), .out_addr(out_addr_a),
        .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a),
        .stall_long(stall_long_a)
    );

    pipe_stage_reg #(.CNT_W(3), .STALL_LIMIT(4)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall),
        .flush(flush), .clr_cnt(clr_cnt), .in_data(in_data),
        .in_ctrl(in_ctrl), .in_addr(in_addr), .out_valid(out_valid_b),
        .out_data(out_data_b), .out_ctrl(out_ctrl_b), .out_addr(out_addr_b),
        .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b),
        .stall_long(stall_long_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [BW-1:0] rand_data();
        logic [BW-1:0] d;
        for (int i = 0; i < BW / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic int sat(input int v, input int max);
        return (v > max) ? max : v;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_data = '0; m_ctrl = '0; m_addr = '0;
        m_stall_ev = 0; m_flush_ev = 0; m_run = 0;
    endtask

    // Apply one clock edge's worth of behaviour to the model.
    task automatic model_edge();
        if (clr_cnt) begin
            m_stall_ev = 0;
            m_flush_ev = 0;
        end else begin
            if (stall && !flush) m_stall_ev++;
            if (flush && m_valid) m_flush_ev++;
        end
        if (stall && !flush) m_run = (m_run < 1000) ? m_run + 1 : m_run;
        else                 m_run = 0;
        if (flush) begin
            m_valid = 1'b0;
            m_ctrl  = '0;
        end else if (!stall) begin
            m_valid = in_valid;
            m_data  = in_data;
            m_addr  = in_addr;
            m_ctrl  = in_valid ? in_ctrl : '0;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic f, input logic c);
        in_valid = v; stall = s; flush = f; clr_cnt = c;
        in_data  = rand_data();
        in_ctrl  = CW'($urandom);
        in_addr  = AW'($urandom);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        model_reset();
        #12;
        total_cnt++; if (out_valid_a !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid_a); else pass_cnt++;
        total_cnt++; if (out_data_a !== '0) $display("FAIL reset_data: got %h want 0", out_data_a); else pass_cnt++;
        total_cnt++; if (out_ctrl_a !== '0 || out_addr_a !== '0) $display("FAIL reset_ctrl_addr: got %h/%h want 0/0", out_ctrl_a, out_addr_a); else pass_cnt++;
        total_cnt++; if (stall_cnt_a !== '0 || flush_cnt_a !== '0 || stall_long_a !== 1'b0) $display("FAIL reset_cnt: got %0d/%0d/%b want 0/0/0", stall_cnt_a, flush_cnt_a, stall_long_a); else pass_cnt++;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_load();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        in_ctrl = 11'h7FF; in_addr = 5'd17; in_data[63:0] = 64'h1000;
        tick();
        total_cnt++; if (out_valid_a !== 1'b1) $display("FAIL load_valid: got %b want 1", out_valid_a); else pass_cnt++;
        total_cnt++; if (out_ctrl_a !== 11'h7FF) $display("FAIL load_ctrl: got %h want 7ff", out_ctrl_a); else pass_cnt++;
        total_cnt++; if (out_addr_a !== 5'd17) $display("FAIL load_addr: got %0d want 17", out_addr_a); else pass_cnt++;
        total_cnt++; if (out_data_a[63:0] !== 64'h1000) $display("FAIL load_word0: got %h want 1000", out_data_a[63:0]); else pass_cnt++;
        total_cnt++; if (out_data_a !== m_data) $display("FAIL load_data: got %h want %h", out_data_a, m_data); else pass_cnt++;
    endtask

    task automatic test_bubble();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        in_ctrl = 11'h7FF;
        tick();
        total_cnt++; if (out_valid_a !== 1'b0) $display("FAIL bubble_valid: got %b want 0", out_valid_a); else pass_cnt++;
        total_cnt++; if (out_ctrl_a !== '0) $display("FAIL bubble_ctrl: got %h want 0", out_ctrl_a); else pass_cnt++;
        total_cnt++; if (out_addr_a !== m_addr) $display("FAIL bubble_addr: got %0d want %0d", out_addr_a, m_addr); else pass_cnt++;
    endtask

    task automatic test_stall_flush();
        logic [BW-1:0] held_data;
        logic [CW-1:0] held_ctrl;
        logic [AW-1:0] held_addr;
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        in_ctrl = 11'h5A3;
        tick();
        held_data = in_data; held_ctrl = 11'h5A3; held_addr = in_addr;
        for (int i = 0; i < 3; i++) begin
            drive(i[0], 1'b1, 1'b0, 1'b0);
            tick();
            total_cnt++;
            if (out_valid_a !== 1'b1 || out_data_a !== held_data || out_ctrl_a !== held_ctrl || out_addr_a !== held_addr)
                $display("FAIL stall_hold[%0d]: got v=%b ctrl=%h addr=%0d want v=1 ctrl=%h addr=%0d", i, out_valid_a, out_ctrl_a, out_addr_a, held_ctrl, held_addr);
            else pass_cnt++;
        end
        total_cnt++; if (stall_cnt_a !== 16'd3) $display("FAIL stall_cnt3: got %0d want 3", stall_cnt_a); else pass_cnt++;
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        total_cnt++; if (out_valid_a !== 1'b0 || out_ctrl_a !== '0) $display("FAIL flush_bubble: got v=%b ctrl=%h want v=0 ctrl=0", out_valid_a, out_ctrl_a); else pass_cnt++;
        total_cnt++; if (flush_cnt_a !== 16'd1) $display("FAIL flush_cnt1: got %0d want 1", flush_cnt_a); else pass_cnt++;
        total_cnt++; if (out_data_a !== held_data || out_addr_a !== held_addr) $display("FAIL flush_hold: got addr=%0d want %0d", out_addr_a, held_addr); else pass_cnt++;
        total_cnt++; if (stall_cnt_a !== 16'd3) $display("FAIL flush_no_stall_inc: got %0d want 3", stall_cnt_a); else pass_cnt++;
    endtask

    task automatic test_stall_long();
        for (int i = 1; i <= 6; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0);
            tick();
            total_cnt++;
            if (stall_long_b !== (i >= 4)) $display("FAIL stall_long_b[%0d]: got %b want %b", i, stall_long_b, (i >= 4));
            else pass_cnt++;
        end
        total_cnt++; if (stall_long_a !== 1'b0) $display("FAIL stall_long_a_6: got %b want 0", stall_long_a); else pass_cnt++;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        total_cnt++; if (stall_long_b !== 1'b0) $display("FAIL stall_long_drop: got %b want 0", stall_long_b); else pass_cnt++;
        // stall+flush together must behave as flush: run restarts.
        for (int i = 0; i < 3; i++) begin drive(1'b1, 1'b1, 1'b0, 1'b0); tick(); end
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        total_cnt++; if (stall_long_b !== 1'b0) $display("FAIL stall_flush_run_clear: got %b want 0", stall_long_b); else pass_cnt++;
    endtask

    task automatic test_saturate();
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 9; i++) begin drive(1'b1, 1'b1, 1'b0, 1'b0); tick(); end
        total_cnt++; if (stall_cnt_b !== 3'd7) $display("FAIL sat_stall_cnt_b: got %0d want 7", stall_cnt_b); else pass_cnt++;
        total_cnt++; if (stall_cnt_a !== 16'd9) $display("FAIL sat_stall_cnt_a: got %0d want 9", stall_cnt_a); else pass_cnt++;
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        total_cnt++; if (stall_cnt_b !== 3'd0 || stall_cnt_a !== 16'd0) $display("FAIL clr_override: got %0d/%0d want 0/0", stall_cnt_b, stall_cnt_a); else pass_cnt++;
        total_cnt++; if (stall_long_b !== 1'b1) $display("FAIL clr_keeps_run: got %b want 1", stall_long_b); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 2; i++) begin drive(1'b1, 1'b1, 1'b0, 1'b0); tick(); end
        #3 reset = 1'b0;
        #1;
        model_reset();
        total_cnt++;
        if (out_valid_a !== 1'b0 || out_data_a !== '0 || out_ctrl_a !== '0 || out_addr_a !== '0)
            $display("FAIL async_reset_stage: got v=%b ctrl=%h addr=%0d want all 0", out_valid_a, out_ctrl_a, out_addr_a);
        else pass_cnt++;
        total_cnt++;
        if (stall_cnt_a !== '0 || flush_cnt_a !== '0 || stall_long_b !== 1'b0 || stall_cnt_b !== '0)
            $display("FAIL async_reset_cnt: got %0d/%0d/%b want 0/0/0", stall_cnt_a, flush_cnt_a, stall_long_b);
        else pass_cnt++;
        #1 reset = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        in_ctrl = 11'h7FF; in_addr = 5'd17; in_data[63:0] = 64'h1000;
        tick();
        total_cnt++;
        if (out_valid_a !== 1'b1 || out_ctrl_a !== 11'h7FF || out_addr_a !== 5'd17 || out_data_a[63:0] !== 64'h1000)
            $display("FAIL post_reset_load: got v=%b ctrl=%h addr=%0d w0=%h want 1/7ff/17/1000", out_valid_a, out_ctrl_a, out_addr_a, out_data_a[63:0]);
        else pass_cnt++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
                  $urandom_range(0, 19) < 3, $urandom_range(0, 19) == 0);
            tick();
            total_cnt++;
            if (out_valid_a !== m_valid || out_ctrl_a !== m_ctrl || out_addr_a !== m_addr || out_data_a !== m_data)
                $display("FAIL rand_stage[%0d]: got v=%b ctrl=%h addr=%0d want v=%b ctrl=%h addr=%0d", n, out_valid_a, out_ctrl_a, out_addr_a, m_valid, m_ctrl, m_addr);
            else pass_cnt++;
            total_cnt++;
            if (int'(stall_cnt_a) != sat(m_stall_ev, 65535) || int'(flush_cnt_a) != sat(m_flush_ev, 65535))
                $display("FAIL rand_cnt_a[%0d]: got %0d/%0d want %0d/%0d", n, stall_cnt_a, flush_cnt_a, sat(m_stall_ev, 65535), sat(m_flush_ev, 65535));
            else pass_cnt++;
            total_cnt++;
            if (int'(stall_cnt_b) != sat(m_stall_ev, 7) || int'(flush_cnt_b) != sat(m_flush_ev, 7))
                $display("FAIL rand_cnt_b[%0d]: got %0d/%0d want %0d/%0d", n, stall_cnt_b, flush_cnt_b, sat(m_stall_ev, 7), sat(m_flush_ev, 7));
            else pass_cnt++;
            total_cnt++;
            if (stall_long_a !== (m_run >= 8) || stall_long_b !== (m_run >= 4))
                $display("FAIL rand_stall_long[%0d]: got %b/%b want %b/%b", n, stall_long_a, stall_long_b, (m_run >= 8), (m_run >= 4));
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_bubble();
        test_stall_flush();
        test_stall_long();
        test_saturate();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
